// File: rtl/adder_pkg.sv
// Shared encodings for the nibble-serial adder: FSM states and the nibble width.
package adder_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder: s = a + b + ci, co = carry out of bit 3.
module ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple adder, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_next;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [3:0]       s4;
    logic             c4;

    ripple_adder u_nibble_add (
        .a  (a_sh[NIBBLE-1:0]),
        .b  (b_sh[NIBBLE-1:0]),
        .ci (cy),
        .s  (s4),
        .co (c4)
    );

    // Result nibbles enter at the top so after N steps the LSB nibble lands at bit 0.
    always_comb begin
        sum_next = sum >> NIBBLE;
        sum_next[WIDTH-1 -: NIBBLE] = s4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cy    <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> NIBBLE;
                    b_sh <= b_sh >> NIBBLE;
                    sum  <= sum_next;
                    cy   <= c4;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        cout  <= c4;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        d16_in_valid, d16_in_ready, d16_cin, d16_out_valid, d16_out_ready, d16_cout;
    logic [15:0] d16_a, d16_b, d16_sum;
    logic        d4_in_valid, d4_in_ready, d4_cin, d4_out_valid, d4_out_ready, d4_cout;
    logic [3:0]  d4_a, d4_b, d4_sum;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .cin(d16_cin),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .sum(d16_sum), .cout(d16_cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .cin(d4_cin),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .sum(d4_sum), .cout(d4_cout)
    );

    int errors = 0;
    int checks = 0;

    logic [16:0] q16[$];
    logic [4:0]  q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitors: a handshake is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (!rst && d16_out_valid && d16_out_ready) begin
            if (q16.size() == 0) begin
                chk("mon16_unexpected_result", 32'(d16_out_valid), 32'd0);
            end else begin
                logic [16:0] e;
                e = q16.pop_front();
                chk("mon16_sum", 32'(d16_sum), 32'(e[15:0]));
                chk("mon16_cout", 32'(d16_cout), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d4_out_valid && d4_out_ready) begin
            if (q4.size() == 0) begin
                chk("mon4_unexpected_result", 32'(d4_out_valid), 32'd0);
            end else begin
                logic [4:0] e;
                e = q4.pop_front();
                chk("mon4_sum", 32'(d4_sum), 32'(e[3:0]));
                chk("mon4_cout", 32'(d4_cout), 32'(e[4]));
            end
        end
    end

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
        logic [16:0] e;
        int n;
        e = {1'b0, a} + {1'b0, b} + {16'd0, c};
        n = 0;
        while (!d16_in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!d16_in_ready) begin
            chk("op16_in_ready_timeout", 32'(d16_in_ready), 32'd1);
            return;
        end
        d16_a = a; d16_b = b; d16_cin = c; d16_in_valid = 1'b1;
        @(posedge clk);
        q16.push_back(e);
        #1;
        // Operand side toggles freely while busy; it must be ignored.
        d16_in_valid = 1'($urandom);
        d16_a = 16'($urandom); d16_b = 16'($urandom); d16_cin = 1'($urandom);
        n = 0;
        while (!d16_out_valid && n < 50) begin
            @(posedge clk); #1; n++;
            d16_in_valid = 1'($urandom);
        end
        chk("op16_latency", 32'(n), 32'd4);
        for (int i = 0; i < hold; i++) begin
            d16_in_valid = 1'b1;
            d16_a = 16'($urandom); d16_b = 16'($urandom); d16_cin = 1'($urandom);
            chk("hold16_sum", 32'(d16_sum), 32'(e[15:0]));
            chk("hold16_cout", 32'(d16_cout), 32'(e[16]));
            chk("hold16_out_valid", 32'(d16_out_valid), 32'd1);
            chk("hold16_in_ready", 32'(d16_in_ready), 32'd0);
            @(posedge clk); #1;
        end
        d16_in_valid = 1'b0;
        d16_out_ready = 1'b1;
        @(posedge clk); #1;
        d16_out_ready = 1'b0;
        chk("op16_in_ready_after_release", 32'(d16_in_ready), 32'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] e;
        int n;
        e = {1'b0, a} + {1'b0, b} + {4'd0, c};
        d4_a = a; d4_b = b; d4_cin = c; d4_in_valid = 1'b1;
        @(posedge clk);
        q4.push_back(e);
        #1;
        d4_in_valid = 1'b0;
        n = 0;
        while (!d4_out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("op4_latency", 32'(n), 32'd1);
        d4_out_ready = 1'b1;
        @(posedge clk); #1;
        d4_out_ready = 1'b0;
        chk("op4_in_ready_after_release", 32'(d4_in_ready), 32'd1);
    endtask

    initial begin
        d16_in_valid = 0; d16_cin = 0; d16_out_ready = 0; d16_a = '0; d16_b = '0;
        d4_in_valid = 0;  d4_cin = 0;  d4_out_ready = 0;  d4_a = '0;  d4_b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst16_in_ready", 32'(d16_in_ready), 32'd1);
        chk("rst16_out_valid", 32'(d16_out_valid), 32'd0);
        chk("rst16_sum", 32'(d16_sum), 32'd0);
        chk("rst16_cout", 32'(d16_cout), 32'd0);
        chk("rst4_in_ready", 32'(d4_in_ready), 32'd1);
        chk("rst4_out_valid", 32'(d4_out_valid), 32'd0);

        op16(16'h1234, 16'h4321, 1'b0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 0);
        op16(16'hABCD, 16'h1111, 1'b1, 5);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Abort after two RUN cycles; COUT is 1 from the previous result.
        d16_a = 16'h1111; d16_b = 16'h2222; d16_cin = 1'b0; d16_in_valid = 1'b1;
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_sum", 32'(d16_sum), 32'd0);
        chk("abort_cout", 32'(d16_cout), 32'd0);
        chk("abort_out_valid", 32'(d16_out_valid), 32'd0);
        chk("abort_in_ready", 32'(d16_in_ready), 32'd1);
        op16(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        op4(4'h9, 4'h8, 1'b1);
        op4(4'hF, 4'h0, 1'b1);
        op4(4'h3, 4'h4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (2) @(posedge clk); #1;
        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
